execute_unit: RTL and testbench
===============================

# execute_unit

Execute stage of the out-of-order datapath. It holds four parallel functional units, each fed by its own issue slot:
- two general ALUs (A0, A1);
- one saturating multiplier (M);
- one load/store address/data former (LS).

Every unit produces a registered result that carries the source-operand tags and destination tag forward for writeback/forwarding.

## Interface
- No parameters. Operand format everywhere: bits [20:5] = 16-bit data, [4:0] = 5-bit source tag.
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- A0_R0, A0_R1  in  21 each  ALU0 operands A and B
- A0_Rd_tag_in  in  5  ALU0 destination tag
- A0_imm  in  5  ALU0 immediate, zero-extended
- A0_imm_sel  in  1  1 = operand B is the immediate, 0 = A0_R1 data
- A0_op  in  4  ALU0 opcode
- A1_R0, A1_R1, A1_Rd_tag_in, A1_imm, A1_imm_sel, A1_op  in  21/21/5/5/1/4  ALU1, same meaning as ALU0
- M_R0, M_R1, M_Rd_tag_in, M_imm, M_imm_sel  in  21/21/5/5/1  multiplier, same meaning as ALU0
- LS_R0  in  21  address operand
- LS_R1  in  21  store-data operand
- LS_Rd_tag_in  in  5  load destination tag
- A0_res, A1_res, M_res  out  26 each  packed result: [25:10] = result, [9:5] = R1 tag (forced to 0 when imm_sel = 1), [4:0] = R0 tag
- A0_Rd_tag_out, A1_Rd_tag_out, M_Rd_tag_out, LS_Rd_tag_out  out  5 each  destination tag of the result
- LS_data  out  8  store byte
- LS_tag  out  5  store-data source tag
- LS_addr  out  21  {address data[20:5], address tag[4:0]}

## Operation
- Operand B = imm_sel ? {11'b0, imm} : R1[20:5]. Operand A = R0[20:5].
- ALU opcodes (A0 and A1 are identical). Arithmetic is 16-bit modulo, with no flags. Shift amount is B[3:0].
  - 0 ADD A+B; 1 SUB A−B
  - 2 AND; 3 OR; 4 XOR; 5 NAND; 6 NOR; 7 XNOR
  - 8 SLL A<<B; 9 SRL A>>B; 10 SRA A>>>B (arithmetic); 11 ROL A rotate-left B
  - 12 MOV B; 13 SLTU → 16'h0001 if A<B unsigned, else 0; 14 NOT ~A; 15 reserved → 16'h0000
- Multiplier: unsigned 16×16 → 32-bit product.
  - If product > 16'hFFFF, result = 16'hFFFF (saturate).
  - Otherwise result = product[15:0].
- Tag packing for A0/A1/M: res[9:5] = R1[4:0] & ~{5{imm_sel}}; res[4:0] = R0[4:0].
- Destination tags pass through: X_Rd_tag_out = X_Rd_tag_in.
- LS unit:
  - LS_addr = LS_R0 unchanged.
  - LS_data = LS_R1[12:5] (low byte of store data).
  - LS_tag = LS_R1[4:0].
  - LS_Rd_tag_out = LS_Rd_tag_in.
- Units are fully independent. Any combination may be active in the same cycle with no interaction.

## Timing
- Single pipeline register on every output. Inputs sampled at posedge N are visible on the outputs after posedge N, i.e. 1-cycle latency.
- Input-to-register logic is combinational. The multiplier must close timing in one cycle, with no multicycle path.
- Throughput is one new operation per unit per cycle. There is no handshake or stall; inputs are taken every cycle.
- Reset: when rst = 1 at a posedge, every output register (all *_res, *_Rd_tag_out, LS_data, LS_tag, LS_addr) loads 0, regardless of inputs. Normal sampling resumes on the first posedge with rst = 0.
- Reset asserted mid-stream discards the in-flight result of every unit.
- Boundaries:
  - ADD/SUB wrap modulo 2^16 (FFFF+1 → 0000; 0000−1 → FFFF).
  - Shift by 0 returns A.
  - Multiply of exactly FFFF×0001 = FFFF, not flagged.
  - imm_sel = 1 ignores R1 entirely, including its tag.

## Test plan
- ALU ADD: A0 R0 = {1234, 00}, R1 = {5678, 01}, imm_sel = 0, op = 0 → after 1 clk, A0_res = {68AC, 01, 00}. Same stimulus on A1 gives an identical A1_res.
- ALU immediate SUB/ADD: A0 op = 1, imm = 04, imm_sel = 1, R0 = 1234 → {1230, 00, 00}. A1 op = 0, imm = 15, imm_sel = 1 → {1249, 00, 00}; R1 tag is masked.
- Multiplier:
  - 0004×0002 → 0008.
  - 00EA×000B → 0A0E.
  - 00EA×imm 1F → 1C56, tag[9:5] = 0.
  - 0FFF×F002 → FFFF (saturated).
- Wrap/shift/ops: FFFF+0001 → 0000; SRA 8000 by 4 → F800; SLTU 0001<0002 → 0001; op 15 → 0000.
- LS: LS_R0 = {ABCD, 07}, LS_R1 = {12EF, 03}, LS_Rd_tag_in = 09 → LS_addr = {ABCD, 07}, LS_data = EF, LS_tag = 03, LS_Rd_tag_out = 09.
- Reset: drive nonzero inputs on all units, assert rst for 1 cycle → all outputs 0 the next cycle. Deassert → the correct result appears 1 cycle later. Rd_tag_out values track their inputs with 1-cycle delay.

Source files
------------

// File: rtl/execute_unit_if.sv
// Operand/result bundle for the four-unit execute stage.
// Operands are {data[20:5], tag[4:0]}; ALU/MUL results are {result, R1 tag, R0 tag}.
interface execute_unit_if;
  logic [20:0] A0_R0;
  logic [20:0] A0_R1;
  logic [4:0]  A0_Rd_tag_in;
  logic [4:0]  A0_imm;
  logic        A0_imm_sel;
  logic [3:0]  A0_op;

  logic [20:0] A1_R0;
  logic [20:0] A1_R1;
  logic [4:0]  A1_Rd_tag_in;
  logic [4:0]  A1_imm;
  logic        A1_imm_sel;
  logic [3:0]  A1_op;

  logic [20:0] M_R0;
  logic [20:0] M_R1;
  logic [4:0]  M_Rd_tag_in;
  logic [4:0]  M_imm;
  logic        M_imm_sel;

  logic [20:0] LS_R0;
  logic [20:0] LS_R1;
  logic [4:0]  LS_Rd_tag_in;

  logic [25:0] A0_res;
  logic [25:0] A1_res;
  logic [25:0] M_res;
  logic [4:0]  A0_Rd_tag_out;
  logic [4:0]  A1_Rd_tag_out;
  logic [4:0]  M_Rd_tag_out;
  logic [4:0]  LS_Rd_tag_out;
  logic [7:0]  LS_data;
  logic [4:0]  LS_tag;
  logic [20:0] LS_addr;

  modport master (
    output A0_R0, A0_R1, A0_Rd_tag_in, A0_imm, A0_imm_sel, A0_op,
    output A1_R0, A1_R1, A1_Rd_tag_in, A1_imm, A1_imm_sel, A1_op,
    output M_R0, M_R1, M_Rd_tag_in, M_imm, M_imm_sel,
    output LS_R0, LS_R1, LS_Rd_tag_in,
    input  A0_res, A1_res, M_res,
    input  A0_Rd_tag_out, A1_Rd_tag_out, M_Rd_tag_out, LS_Rd_tag_out,
    input  LS_data, LS_tag, LS_addr
  );

  modport slave (
    input  A0_R0, A0_R1, A0_Rd_tag_in, A0_imm, A0_imm_sel, A0_op,
    input  A1_R0, A1_R1, A1_Rd_tag_in, A1_imm, A1_imm_sel, A1_op,
    input  M_R0, M_R1, M_Rd_tag_in, M_imm, M_imm_sel,
    input  LS_R0, LS_R1, LS_Rd_tag_in,
    output A0_res, A1_res, M_res,
    output A0_Rd_tag_out, A1_Rd_tag_out, M_Rd_tag_out, LS_Rd_tag_out,
    output LS_data, LS_tag, LS_addr
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: two ALUs, a saturating multiplier and a load/store former,
// each a purely combinational unit followed by a single result register.
module execute_unit (
  input  logic         clk,
  input  logic         rst,
  execute_unit_if.slave bus
);

  function automatic logic [15:0] operandB(input logic [20:0] r1,
                                           input logic [4:0]  imm,
                                           input logic        immSel);
    return immSel ? {11'b0, imm} : r1[20:5];
  endfunction

  function automatic logic [25:0] packRes(input logic [15:0] result,
                                          input logic [20:0] r0,
                                          input logic [20:0] r1,
                                          input logic        immSel);
    return {result, r1[4:0] & ~{5{immSel}}, r0[4:0]};
  endfunction

  // Rotate is taken from the upper half of a doubled word so a zero amount needs no special case.
  function automatic logic [15:0] aluCompute(input logic [3:0]  op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] rot;
    logic [15:0] sra;
    logic [15:0] res;
    rot = {a, a} << b[3:0];
    sra = $signed(a) >>> b[3:0];
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = ~(a & b);
      4'd6:    res = ~(a | b);
      4'd7:    res = ~(a ^ b);
      4'd8:    res = a << b[3:0];
      4'd9:    res = a >> b[3:0];
      4'd10:   res = sra;
      4'd11:   res = rot[31:16];
      4'd12:   res = b;
      4'd13:   res = (a < b) ? 16'h0001 : 16'h0000;
      4'd14:   res = ~a;
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

  function automatic logic [15:0] mulSat(input logic [15:0] a,
                                         input logic [15:0] b);
    logic [31:0] product;
    product = a * b;
    return (|product[31:16]) ? 16'hFFFF : product[15:0];
  endfunction

  logic [25:0] a0Res_q, a0Res_d;
  logic [25:0] a1Res_q, a1Res_d;
  logic [25:0] mRes_q, mRes_d;
  logic [4:0]  a0Rd_q, a0Rd_d;
  logic [4:0]  a1Rd_q, a1Rd_d;
  logic [4:0]  mRd_q, mRd_d;
  logic [4:0]  lsRd_q, lsRd_d;
  logic [7:0]  lsData_q, lsData_d;
  logic [4:0]  lsTag_q, lsTag_d;
  logic [20:0] lsAddr_q, lsAddr_d;

  // Only the low byte of store data is consumed; the upper byte is dropped here.
  logic unusedLsBits;
  assign unusedLsBits = ^bus.LS_R1[20:13];

  always_comb begin
    a0Res_d = packRes(aluCompute(bus.A0_op, bus.A0_R0[20:5],
                                 operandB(bus.A0_R1, bus.A0_imm, bus.A0_imm_sel)),
                      bus.A0_R0, bus.A0_R1, bus.A0_imm_sel);
    a1Res_d = packRes(aluCompute(bus.A1_op, bus.A1_R0[20:5],
                                 operandB(bus.A1_R1, bus.A1_imm, bus.A1_imm_sel)),
                      bus.A1_R0, bus.A1_R1, bus.A1_imm_sel);
    mRes_d  = packRes(mulSat(bus.M_R0[20:5],
                             operandB(bus.M_R1, bus.M_imm, bus.M_imm_sel)),
                      bus.M_R0, bus.M_R1, bus.M_imm_sel);
    a0Rd_d   = bus.A0_Rd_tag_in;
    a1Rd_d   = bus.A1_Rd_tag_in;
    mRd_d    = bus.M_Rd_tag_in;
    lsRd_d   = bus.LS_Rd_tag_in;
    lsAddr_d = bus.LS_R0;
    lsData_d = bus.LS_R1[12:5];
    lsTag_d  = bus.LS_R1[4:0];
  end

  // Reset flushes every unit's in-flight result at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      a0Res_q  <= '0;
      a1Res_q  <= '0;
      mRes_q   <= '0;
      a0Rd_q   <= '0;
      a1Rd_q   <= '0;
      mRd_q    <= '0;
      lsRd_q   <= '0;
      lsData_q <= '0;
      lsTag_q  <= '0;
      lsAddr_q <= '0;
    end else begin
      a0Res_q  <= a0Res_d;
      a1Res_q  <= a1Res_d;
      mRes_q   <= mRes_d;
      a0Rd_q   <= a0Rd_d;
      a1Rd_q   <= a1Rd_d;
      mRd_q    <= mRd_d;
      lsRd_q   <= lsRd_d;
      lsData_q <= lsData_d;
      lsTag_q  <= lsTag_d;
      lsAddr_q <= lsAddr_d;
    end
  end

  assign bus.A0_res        = a0Res_q;
  assign bus.A1_res        = a1Res_q;
  assign bus.M_res         = mRes_q;
  assign bus.A0_Rd_tag_out = a0Rd_q;
  assign bus.A1_Rd_tag_out = a1Rd_q;
  assign bus.M_Rd_tag_out  = mRd_q;
  assign bus.LS_Rd_tag_out = lsRd_q;
  assign bus.LS_data       = lsData_q;
  assign bus.LS_tag        = lsTag_q;
  assign bus.LS_addr       = lsAddr_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit: one task per scenario,
// expected values hand-computed from the operation definitions.
module tb_execute_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  execute_unit_if ifc ();

  execute_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    ifc.A0_R0 = '0; ifc.A0_R1 = '0; ifc.A0_Rd_tag_in = '0;
    ifc.A0_imm = '0; ifc.A0_imm_sel = 1'b0; ifc.A0_op = '0;
    ifc.A1_R0 = '0; ifc.A1_R1 = '0; ifc.A1_Rd_tag_in = '0;
    ifc.A1_imm = '0; ifc.A1_imm_sel = 1'b0; ifc.A1_op = '0;
    ifc.M_R0 = '0; ifc.M_R1 = '0; ifc.M_Rd_tag_in = '0;
    ifc.M_imm = '0; ifc.M_imm_sel = 1'b0;
    ifc.LS_R0 = '0; ifc.LS_R1 = '0; ifc.LS_Rd_tag_in = '0;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBusyAll();
    ifc.A0_R0 = {16'h1234, 5'h03}; ifc.A0_R1 = {16'h0001, 5'h04};
    ifc.A0_op = 4'd0; ifc.A0_Rd_tag_in = 5'h11;
    ifc.A1_R0 = {16'h00F0, 5'h05}; ifc.A1_R1 = {16'h000F, 5'h06};
    ifc.A1_op = 4'd3; ifc.A1_Rd_tag_in = 5'h12;
    ifc.M_R0 = {16'h0010, 5'h07}; ifc.M_R1 = {16'h0003, 5'h08};
    ifc.M_Rd_tag_in = 5'h13;
    ifc.LS_R0 = {16'hBEEF, 5'h09}; ifc.LS_R1 = {16'h0055, 5'h0A};
    ifc.LS_Rd_tag_in = 5'h14;
  endtask

  task automatic test_reset();
    driveBusyAll();
    rst = 1'b1;
    stepClock();
    total++;
    if (ifc.A0_res !== 26'h0 || ifc.A1_res !== 26'h0 || ifc.M_res !== 26'h0) begin
      bad++;
      $display("FAIL reset_res got a0=%h a1=%h m=%h exp all 0", ifc.A0_res, ifc.A1_res, ifc.M_res);
    end
    total++;
    if (ifc.A0_Rd_tag_out !== 5'h0 || ifc.A1_Rd_tag_out !== 5'h0 ||
        ifc.M_Rd_tag_out !== 5'h0 || ifc.LS_Rd_tag_out !== 5'h0) begin
      bad++;
      $display("FAIL reset_rd got %h %h %h %h exp 0", ifc.A0_Rd_tag_out, ifc.A1_Rd_tag_out,
               ifc.M_Rd_tag_out, ifc.LS_Rd_tag_out);
    end
    total++;
    if (ifc.LS_data !== 8'h0 || ifc.LS_tag !== 5'h0 || ifc.LS_addr !== 21'h0) begin
      bad++;
      $display("FAIL reset_ls got data=%h tag=%h addr=%h exp 0", ifc.LS_data, ifc.LS_tag, ifc.LS_addr);
    end
    rst = 1'b0;
    stepClock();
    total++;
    if (ifc.A0_res !== {16'h1235, 5'h04, 5'h03} || ifc.A0_Rd_tag_out !== 5'h11) begin
      bad++;
      $display("FAIL reset_release got res=%h rd=%h exp %h rd=11", ifc.A0_res, ifc.A0_Rd_tag_out,
               {16'h1235, 5'h04, 5'h03});
    end
    clearInputs();
  endtask

  task automatic test_alu_add();
    ifc.A0_R0 = {16'h1234, 5'h00}; ifc.A0_R1 = {16'h5678, 5'h01};
    ifc.A0_op = 4'd0; ifc.A0_Rd_tag_in = 5'h0A;
    ifc.A1_R0 = {16'h1234, 5'h00}; ifc.A1_R1 = {16'h5678, 5'h01};
    ifc.A1_op = 4'd0; ifc.A1_Rd_tag_in = 5'h0B;
    stepClock();
    total++;
    if (ifc.A0_res !== {16'h68AC, 5'h01, 5'h00}) begin
      bad++;
      $display("FAIL a0_add got=%h exp=%h", ifc.A0_res, {16'h68AC, 5'h01, 5'h00});
    end
    total++;
    if (ifc.A1_res !== {16'h68AC, 5'h01, 5'h00}) begin
      bad++;
      $display("FAIL a1_add got=%h exp=%h", ifc.A1_res, {16'h68AC, 5'h01, 5'h00});
    end
    total++;
    if (ifc.A0_Rd_tag_out !== 5'h0A || ifc.A1_Rd_tag_out !== 5'h0B) begin
      bad++;
      $display("FAIL alu_rd got a0=%h a1=%h exp 0a 0b", ifc.A0_Rd_tag_out, ifc.A1_Rd_tag_out);
    end
    clearInputs();
  endtask

  task automatic test_alu_imm();
    ifc.A0_R0 = {16'h1234, 5'h00}; ifc.A0_R1 = {16'hFFFF, 5'h1F};
    ifc.A0_op = 4'd1; ifc.A0_imm = 5'h04; ifc.A0_imm_sel = 1'b1;
    ifc.A1_R0 = {16'h1234, 5'h02}; ifc.A1_R1 = {16'hAAAA, 5'h1F};
    ifc.A1_op = 4'd0; ifc.A1_imm = 5'h15; ifc.A1_imm_sel = 1'b1;
    stepClock();
    total++;
    if (ifc.A0_res !== {16'h1230, 5'h00, 5'h00}) begin
      bad++;
      $display("FAIL a0_sub_imm got=%h exp=%h", ifc.A0_res, {16'h1230, 5'h00, 5'h00});
    end
    total++;
    if (ifc.A1_res !== {16'h1249, 5'h00, 5'h02}) begin
      bad++;
      $display("FAIL a1_add_imm got=%h exp=%h", ifc.A1_res, {16'h1249, 5'h00, 5'h02});
    end
    clearInputs();
  endtask

  task automatic test_mult();
    logic [15:0] ma [7];
    logic [15:0] mb [7];
    logic        msel [7];
    logic [15:0] mexp [7];
    ma[0] = 16'h0004; mb[0] = 16'h0002; msel[0] = 1'b0; mexp[0] = 16'h0008;
    ma[1] = 16'h00EA; mb[1] = 16'h000B; msel[1] = 1'b0; mexp[1] = 16'h0A0E;
    ma[2] = 16'h00EA; mb[2] = 16'h001F; msel[2] = 1'b1; mexp[2] = 16'h1C56;
    ma[3] = 16'h0FFF; mb[3] = 16'hF002; msel[3] = 1'b0; mexp[3] = 16'hFFFF;
    ma[4] = 16'hFFFF; mb[4] = 16'h0001; msel[4] = 1'b0; mexp[4] = 16'hFFFF;
    ma[5] = 16'h0100; mb[5] = 16'h0100; msel[5] = 1'b0; mexp[5] = 16'hFFFF;
    ma[6] = 16'h00FF; mb[6] = 16'h0101; msel[6] = 1'b0; mexp[6] = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      ifc.M_R0 = {ma[i], 5'h06};
      ifc.M_R1 = {msel[i] ? 16'h7777 : mb[i], 5'h19};
      ifc.M_imm = mb[i][4:0];
      ifc.M_imm_sel = msel[i];
      ifc.M_Rd_tag_in = 5'(i + 1);
      stepClock();
      total++;
      if (ifc.M_res !== {mexp[i], (msel[i] ? 5'h00 : 5'h19), 5'h06} ||
          ifc.M_Rd_tag_out !== 5'(i + 1)) begin
        bad++;
        $display("FAIL mult_%0d got res=%h rd=%h exp res=%h rd=%h", i, ifc.M_res, ifc.M_Rd_tag_out,
                 {mexp[i], (msel[i] ? 5'h00 : 5'h19), 5'h06}, 5'(i + 1));
      end
    end
    clearInputs();
  endtask

  task automatic test_ops();
    logic [3:0]  opv [10];
    logic [15:0] av  [10];
    logic [15:0] bv  [10];
    logic [15:0] ev  [10];
    opv[0] = 4'd0;  av[0] = 16'hFFFF; bv[0] = 16'h0001; ev[0] = 16'h0000;
    opv[1] = 4'd1;  av[1] = 16'h0000; bv[1] = 16'h0001; ev[1] = 16'hFFFF;
    opv[2] = 4'd10; av[2] = 16'h8000; bv[2] = 16'h0004; ev[2] = 16'hF800;
    opv[3] = 4'd13; av[3] = 16'h0001; bv[3] = 16'h0002; ev[3] = 16'h0001;
    opv[4] = 4'd15; av[4] = 16'h1234; bv[4] = 16'h5678; ev[4] = 16'h0000;
    opv[5] = 4'd8;  av[5] = 16'hABCD; bv[5] = 16'h0000; ev[5] = 16'hABCD;
    opv[6] = 4'd11; av[6] = 16'h8001; bv[6] = 16'h0001; ev[6] = 16'h0003;
    opv[7] = 4'd9;  av[7] = 16'h8000; bv[7] = 16'h0004; ev[7] = 16'h0800;
    opv[8] = 4'd5;  av[8] = 16'hF0F0; bv[8] = 16'hFF00; ev[8] = 16'h0FFF;
    opv[9] = 4'd13; av[9] = 16'h0002; bv[9] = 16'h0002; ev[9] = 16'h0000;
    for (int i = 0; i < 10; i += 2) begin
      ifc.A0_op = opv[i];   ifc.A0_R0 = {av[i], 5'h01};   ifc.A0_R1 = {bv[i], 5'h02};
      ifc.A1_op = opv[i+1]; ifc.A1_R0 = {av[i+1], 5'h03}; ifc.A1_R1 = {bv[i+1], 5'h04};
      stepClock();
      total++;
      if (ifc.A0_res !== {ev[i], 5'h02, 5'h01}) begin
        bad++;
        $display("FAIL op_%0d_a0 got=%h exp=%h", i, ifc.A0_res, {ev[i], 5'h02, 5'h01});
      end
      total++;
      if (ifc.A1_res !== {ev[i+1], 5'h04, 5'h03}) begin
        bad++;
        $display("FAIL op_%0d_a1 got=%h exp=%h", i + 1, ifc.A1_res, {ev[i+1], 5'h04, 5'h03});
      end
    end
    clearInputs();
  endtask

  task automatic test_ls();
    ifc.LS_R0 = {16'hABCD, 5'h07};
    ifc.LS_R1 = {16'h12EF, 5'h03};
    ifc.LS_Rd_tag_in = 5'h09;
    stepClock();
    total++;
    if (ifc.LS_addr !== {16'hABCD, 5'h07} || ifc.LS_data !== 8'hEF ||
        ifc.LS_tag !== 5'h03 || ifc.LS_Rd_tag_out !== 5'h09) begin
      bad++;
      $display("FAIL ls got addr=%h data=%h tag=%h rd=%h exp addr=%h data=ef tag=03 rd=09",
               ifc.LS_addr, ifc.LS_data, ifc.LS_tag, ifc.LS_Rd_tag_out, {16'hABCD, 5'h07});
    end
    clearInputs();
  endtask

  task automatic test_back_to_back();
    ifc.A0_R0 = {16'h0010, 5'h01}; ifc.A0_R1 = {16'h0020, 5'h02}; ifc.A0_op = 4'd0;
    ifc.A0_Rd_tag_in = 5'h05;
    stepClock();
    ifc.A0_R0 = {16'h00FF, 5'h03}; ifc.A0_R1 = {16'h0F0F, 5'h04}; ifc.A0_op = 4'd4;
    ifc.A0_Rd_tag_in = 5'h06;
    total++;
    if (ifc.A0_res !== {16'h0030, 5'h02, 5'h01} || ifc.A0_Rd_tag_out !== 5'h05) begin
      bad++;
      $display("FAIL b2b_first got res=%h rd=%h exp %h rd=05", ifc.A0_res, ifc.A0_Rd_tag_out,
               {16'h0030, 5'h02, 5'h01});
    end
    stepClock();
    total++;
    if (ifc.A0_res !== {16'h0FF0, 5'h04, 5'h03} || ifc.A0_Rd_tag_out !== 5'h06) begin
      bad++;
      $display("FAIL b2b_second got res=%h rd=%h exp %h rd=06", ifc.A0_res, ifc.A0_Rd_tag_out,
               {16'h0FF0, 5'h04, 5'h03});
    end
    driveBusyAll();
    stepClock();
    rst = 1'b1;
    stepClock();
    total++;
    if (ifc.A0_res !== 26'h0 || ifc.M_res !== 26'h0 || ifc.LS_addr !== 21'h0 ||
        ifc.LS_Rd_tag_out !== 5'h0) begin
      bad++;
      $display("FAIL midstream_reset got a0=%h m=%h addr=%h rd=%h exp 0", ifc.A0_res, ifc.M_res,
               ifc.LS_addr, ifc.LS_Rd_tag_out);
    end
    rst = 1'b0;
    stepClock();
    total++;
    if (ifc.M_res !== {16'h0030, 5'h08, 5'h07} || ifc.A1_res !== {16'h00FF, 5'h06, 5'h05}) begin
      bad++;
      $display("FAIL midstream_resume got m=%h a1=%h exp m=%h a1=%h", ifc.M_res, ifc.A1_res,
               {16'h0030, 5'h08, 5'h07}, {16'h00FF, 5'h06, 5'h05});
    end
    clearInputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clearInputs();
    #1;
    test_reset();
    test_alu_add();
    test_alu_imm();
    test_mult();
    test_ops();
    test_ls();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
